// File: rtl/ceff_rr_arbiter_if.sv
// rtl/ceff_rr_arbiter_if.sv - handshake bundle between requesters, arbiter and consumer
//
// Purpose: groups the request/grant side and the capture/ack side of
// ceff_rr_arbiter into one interface.
// Signals:
//   req_valid_i [NREQ]       per-requester request
//   req_data_i  [NREQ*SIZE]  requester k data on [k*SIZE +: SIZE]
//   req_ready_o [NREQ]       one-hot grant
//   data_o      [SIZE]       captured data
//   src_o       [SRCW]       index of requester whose data is held
//   valid_o                  capture register holds an unacknowledged word
//   ack_i                    consumer accepts the held word
// Modports: slave = arbiter side, master = requester/consumer side.
interface ceff_rr_arbiter_if #(
  parameter int SIZE = 1,
  parameter int NREQ = 2
);
  localparam int SRCW = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ*SIZE-1:0] req_data_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [SIZE-1:0]      data_o;
  logic [SRCW-1:0]      src_o;
  logic                 valid_o;
  logic                 ack_i;

  modport slave (
    input  req_valid_i, req_data_i, ack_i,
    output req_ready_o, data_o, src_o, valid_o
  );

  modport master (
    output req_valid_i, req_data_i, ack_i,
    input  req_ready_o, data_o, src_o, valid_o
  );
endinterface

// File: rtl/ceff_rr_arbiter.sv
// rtl/ceff_rr_arbiter.sv - round-robin arbiter feeding a single capture register
//
// Purpose: grants one of NREQ requesters per capture, latches its data and
// index, and holds the word until the consumer acknowledges it. A new winner
// is captured on the same edge as the ack, so ack held high gives one
// capture per cycle.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   arb_if       ceff_rr_arbiter_if.slave (requests, grant, captured word, ack)
//   grant_cnt_o  16-bit saturating capture counter, present only when
//                CEFF_RR_ARBITER_STATS_EN is defined
module ceff_rr_arbiter #(
  parameter int SIZE = 1,
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  ceff_rr_arbiter_if.slave     arb_if
`ifdef CEFF_RR_ARBITER_STATS_EN
  ,
  output logic [15:0]          grant_cnt_o
`endif
);
  localparam int SRCW = $clog2(NREQ);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t          state_q;
  logic [SIZE-1:0] data_q;
  logic [SRCW-1:0] src_q;
  logic            valid_q;
  logic [SRCW-1:0] ptr_q;

  logic            any_req;
  logic [SRCW-1:0] winner;
  logic [SIZE-1:0] winner_data;
  logic            cap_ok;
  logic            capture;
  logic [SRCW-1:0] ptr_d;
  int unsigned     scan_idx;

  // Scan from ptr_q upward with wrap; the first valid requester wins.
  always_comb begin
    any_req  = 1'b0;
    winner   = '0;
    scan_idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= NREQ) begin
        scan_idx = scan_idx - NREQ;
      end
      if (!any_req && arb_if.req_valid_i[scan_idx]) begin
        any_req = 1'b1;
        winner  = SRCW'(scan_idx);
      end
    end
  end

  assign winner_data = arb_if.req_data_i[int'(winner)*SIZE +: SIZE];

  // ack while FULL frees the register on the same edge that refills it.
  assign cap_ok  = (state_q == ST_EMPTY) | arb_if.ack_i;
  assign capture = any_req & cap_ok & ~reset;
  assign ptr_d   = (winner == SRCW'(NREQ - 1)) ? '0 : winner + SRCW'(1);

  assign arb_if.req_ready_o = capture ? (NREQ'(1) << winner) : '0;
  assign arb_if.data_o      = data_q;
  assign arb_if.src_o       = src_q;
  assign arb_if.valid_o     = valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (any_req) begin
            state_q <= ST_FULL;
            valid_q <= 1'b1;
            data_q  <= winner_data;
            src_q   <= winner;
            ptr_q   <= ptr_d;
          end
        end
        ST_FULL: begin
          if (arb_if.ack_i) begin
            if (any_req) begin
              data_q <= winner_data;
              src_q  <= winner;
              ptr_q  <= ptr_d;
            end else begin
              state_q <= ST_EMPTY;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CEFF_RR_ARBITER_STATS_EN
  logic [15:0] grant_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt_q <= '0;
    end else if (capture && (grant_cnt_q != 16'hFFFF)) begin
      grant_cnt_q <= grant_cnt_q + 16'd1;
    end
  end

  assign grant_cnt_o = grant_cnt_q;
`endif
endmodule

// File: tb/tb_ceff_rr_arbiter.sv
// tb/tb_ceff_rr_arbiter.sv - self-checking bench for ceff_rr_arbiter
module tb_ceff_rr_arbiter;
  localparam int SIZE = 8;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ceff_rr_arbiter_if #(.SIZE(SIZE), .NREQ(NREQ)) arb_if ();

`ifdef CEFF_RR_ARBITER_STATS_EN
  logic [15:0] grant_cnt;
`endif

  ceff_rr_arbiter #(.SIZE(SIZE), .NREQ(NREQ)) dut (
    .clk    (clk),
    .reset  (reset),
    .arb_if (arb_if)
`ifdef CEFF_RR_ARBITER_STATS_EN
    ,
    .grant_cnt_o (grant_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: held word, pointer, capture count.
  int       m_ptr;
  bit       m_valid;
  int       m_data;
  int       m_src;
  int       m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner = valid requester at the smallest circular distance from ptr.
  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = NREQ;
    for (int k = 0; k < NREQ; k++) begin
      if (v[k]) begin
        d = (k - ptr + NREQ) % NREQ;
        if (d < bestd) begin
          bestd = d;
          best  = k;
        end
      end
    end
    return best;
  endfunction

  function automatic int word_of(input logic [NREQ*SIZE-1:0] bus, input int k);
    return int'(bus[k*SIZE +: SIZE]);
  endfunction

  // One clock: inputs already applied; check grant, clock, update model, check state.
  task automatic step(input string tag);
    int              w;
    bit              cap_ok;
    logic [NREQ-1:0] exp_rdy;
    bit              cap;
    #2;
    w       = pick(arb_if.req_valid_i, m_ptr);
    cap_ok  = !m_valid || arb_if.ack_i;
    cap     = !reset && (w >= 0) && cap_ok;
    exp_rdy = cap ? (NREQ'(1) << w) : '0;
    chk({tag, ".ready"}, 32'(arb_if.req_ready_o), 32'(exp_rdy));
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0; m_cnt = 0;
    end else if (cap) begin
      m_valid = 1;
      m_data  = word_of(arb_if.req_data_i, w);
      m_src   = w;
      m_ptr   = (w + 1) % NREQ;
      if (m_cnt < 16'hFFFF) m_cnt++;
    end else if (m_valid && arb_if.ack_i) begin
      m_valid = 0;
    end
    #1;
    chk({tag, ".valid"}, 32'(arb_if.valid_o), 32'(m_valid));
    chk({tag, ".data"},  32'(arb_if.data_o),  32'(m_data));
    chk({tag, ".src"},   32'(arb_if.src_o),   32'(m_src));
`ifdef CEFF_RR_ARBITER_STATS_EN
    chk({tag, ".cnt"},   32'(grant_cnt),      32'(m_cnt));
`endif
  endtask

  initial begin
    m_ptr = 0; m_valid = 0; m_data = 0; m_src = 0; m_cnt = 0;
    reset = 1'b1;
    arb_if.req_valid_i = '0;
    arb_if.req_data_i  = '0;
    arb_if.ack_i       = 1'b0;

    // Reset and idle.
    step("rst");
    step("rst");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step("idle");

    // Single request from requester 2, hold, then ack.
    arb_if.req_valid_i = 4'b0100;
    arb_if.req_data_i  = {8'h00, 8'hA5, 8'h00, 8'h00};
    step("single");
    chk("single.src2", 32'(arb_if.src_o), 32'd2);
    chk("single.dataA5", 32'(arb_if.data_o), 32'hA5);
    arb_if.req_valid_i = '0;
    for (int i = 0; i < 3; i++) step("hold");
    arb_if.ack_i = 1'b1;
    step("ack");
    arb_if.ack_i = 1'b0;
    step("empty");

    // Reset pointer, then all four requesters back-to-back.
    reset = 1'b1;
    step("rst2");
    reset = 1'b0;
    arb_if.req_valid_i = 4'b1111;
    arb_if.req_data_i  = {8'h13, 8'h12, 8'h11, 8'h10};
    step("rr0");
    chk("rr.first_src0", 32'(arb_if.src_o), 32'd0);
    arb_if.ack_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step("rr");
      chk("rr.seq", 32'(arb_if.src_o), 32'((i + 1) % NREQ));
      chk("rr.seqdata", 32'(arb_if.data_o), 32'(8'h10 + ((i + 1) % NREQ)));
    end
    arb_if.req_valid_i = '0;
    step("rr.drain");

    // FULL holding src 1 while requester 3 waits without ack.
    arb_if.ack_i       = 1'b0;
    arb_if.req_valid_i = 4'b0010;
    arb_if.req_data_i  = {8'h33, 8'h22, 8'h11, 8'h00};
    step("f1");
    chk("f1.src1", 32'(arb_if.src_o), 32'd1);
    arb_if.req_valid_i = 4'b1000;
    for (int i = 0; i < 4; i++) step("stall");
    arb_if.ack_i = 1'b1;
    step("b2b");
    chk("b2b.src3", 32'(arb_if.src_o), 32'd3);
    arb_if.req_valid_i = '0;
    step("b2b.drain");
    arb_if.ack_i = 1'b0;

    // Reset while FULL with requester 0 still pending.
    arb_if.req_valid_i = 4'b0001;
    step("pre_rst");
    reset = 1'b1;
    step("mid_rst");
    reset = 1'b0;
    step("post_rst");
    chk("post_rst.src0", 32'(arb_if.src_o), 32'd0);
    arb_if.req_valid_i = '0;
    arb_if.ack_i       = 1'b1;
    step("post_rst.drain");

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      arb_if.req_valid_i = NREQ'($urandom);
      arb_if.req_data_i  = ($urandom);
      arb_if.ack_i       = $urandom_range(0, 1);
      reset              = ($urandom_range(0, 63) == 0);
      step("rand");
    end
    reset = 1'b0;

`ifdef CEFF_RR_ARBITER_STATS_EN
    // Saturation of the capture counter.
    reset = 1'b1;
    step("sat.rst");
    reset = 1'b0;
    arb_if.req_valid_i = 4'b1111;
    arb_if.ack_i       = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      arb_if.req_data_i = ($urandom);
      step("sat");
    end
    chk("sat.ffff", 32'(grant_cnt), 32'hFFFF);
    reset = 1'b1;
    step("sat.clr");
    chk("sat.zero", 32'(grant_cnt), 32'd0);
    reset = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ceff_rr_arbiter.md
Name: ceff_rr_arbiter

Overview:
- Round-robin arbiter that shares one capture register among NREQ requesters.
- Each requester presents valid and data. The arbiter grants one requester per capture and latches its data and source index.
- The captured word is held until the downstream consumer acknowledges it.
- Sits between multiple producer stages and a single downstream consumer, in front of a capture-enable register stage.

Parameters:
- SIZE, 1, data width in bits per requester and of data_o.
- NREQ, 2, number of requesters; legal range 2..16.
- SRCW (localparam), $clog2(NREQ), width of the source index.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid_i  input  NREQ  per-requester request; bit k belongs to requester k.
- req_data_i  input  NREQ*SIZE  requester k data on bits [k*SIZE +: SIZE].
- req_ready_o  output  NREQ  one-hot grant; requester k's word is captured at the clock edge where req_valid_i[k] and req_ready_o[k] are both 1.
- data_o  output  SIZE  captured data.
- src_o  output  SRCW  index of the requester whose data is held.
- valid_o  output  1  capture register holds an unacknowledged word.
- ack_i  input  1  consumer accepts the held word; ignored when valid_o=0.

Behaviour:
- Reset values (next edge with reset=1): data_o=0, src_o=0, valid_o=0, round-robin pointer ptr=0. req_ready_o is forced to 0 while reset=1.
- State machine, 2 states:
  - EMPTY (valid_o=0): if any req_valid_i, grant the winner, capture it, go to FULL. Otherwise stay in EMPTY.
  - FULL (valid_o=1), ack_i=0: hold data_o and src_o unchanged; req_ready_o=0.
  - FULL, ack_i=1 with a request pending: capture the new winner in the same edge and stay in FULL (back-to-back, no bubble).
  - FULL, ack_i=1 with no request: go to EMPTY.
- Capture opportunity: cap_ok = (state==EMPTY) | ack_i.
- Grant (combinational):
  - Search requesters starting at index ptr, ascending, wrapping at NREQ-1 -> 0.
  - The first k with req_valid_i[k]=1 wins.
  - req_ready_o = onehot(winner) & {NREQ{cap_ok}}; all zeros when there is no request.
- Pointer: on each capture, ptr <= (winner==NREQ-1) ? 0 : winner+1. Unchanged otherwise.
- Latency: a request arriving while EMPTY is visible on valid_o/data_o one cycle later.
- Throughput: one capture per cycle when ack_i is held at 1.
- Fairness: with all requesters continuously valid and ack_i=1, grants cycle 0,1,...,NREQ-1,0,... Any requester waits at most NREQ-1 captures.
- Requesters may drop req_valid_i without being granted (no stickiness). The arbiter does not require requesters to hold valid.
- ack_i while EMPTY has no effect. cap_ok is already 1 in EMPTY, so behaviour is identical to ack_i=0.
- Reset asserted mid-transfer discards the held word. The reset values apply on that edge and no grant is issued in that cycle.
- Single-requester case: the pointer still advances, but the same requester wins every capture.

Optional Feature:
- Macro: CEFF_RR_ARBITER_STATS_EN.
- When defined, add output grant_cnt_o (16 bits):
  - Counts captures; saturates at 16'hFFFF.
  - Reset value 0.
  - Increments on every edge where a capture occurs.
- When undefined, the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset, then all req_valid_i=0 for 5 cycles -> valid_o=0, req_ready_o=0, data_o=0, src_o=0 throughout.
- NREQ=4, SIZE=8, req 2 only, data 8'hA5 for one cycle while EMPTY -> next cycle valid_o=1, data_o=8'hA5, src_o=2. Holds while ack_i=0. ack_i=1 -> valid_o=0 the next cycle.
- All 4 valid with data 8'h10,8'h11,8'h12,8'h13, ack_i=1 constantly after the first capture -> src_o sequence 0,1,2,3,0,1 with matching data on consecutive cycles and no bubbles.
- FULL holding src 1, req 3 valid, ack_i=0 for 4 cycles -> req_ready_o=0, outputs stable. ack_i=1 -> same edge captures src 3, valid_o stays 1.
- reset=1 asserted while FULL with req 0 valid -> next cycle valid_o=0, ptr=0. After reset release, req 0 is granted first.
- With CEFF_RR_ARBITER_STATS_EN: 70000 back-to-back captures -> grant_cnt_o=16'hFFFF, no wrap. After reset -> 0.
